// File: rtl/n_bit_sync_down_counter.sv
// Synchronous loadable N-bit down counter / interval timer.
// Counts a loaded value down to zero and raises a one-cycle terminal-count
// pulse. It then either reloads and keeps running, or stops in IDLE.
// All state, including the outputs, changes only on the rising clock edge.
module n_bit_sync_down_counter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         start,
    input  logic         stop,
    input  logic         en,
    input  logic         auto_reload,
    output logic [N-1:0] qout,
    output logic         tc,
    output logic         busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] count;
    logic [N-1:0] count_next;
    logic [N-1:0] reload_reg;
    logic [N-1:0] reload_next;
    logic         tc_reg;
    logic         tc_next;
    logic         at_zero;
    logic         counting;

    // The count is "consumed" only in RUN with enable high and no load/stop override
    assign at_zero  = (count == '0);
    assign counting = !load && !stop && (state == RUN) && en;

    // State and datapath registers; synchronous active-low reset clears everything
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            tc_reg     <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            reload_reg <= reload_next;
            tc_reg     <= tc_next;
        end
    end

    // Next-state logic: load beats stop, stop beats start and counting
    always_comb begin
        state_next = state;
        if (load) begin
            state_next = IDLE;
        end else if (stop) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (en && at_zero && !auto_reload) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath next values: load capture, decrement, terminal pulse and reload
    always_comb begin
        count_next  = count;
        reload_next = reload_reg;
        tc_next     = 1'b0;
        if (load) begin
            count_next  = load_val;
            reload_next = load_val;
        end else if (counting) begin
            if (at_zero) begin
                tc_next = 1'b1;
                if (auto_reload) begin
                    count_next = reload_reg;
                end
            end else begin
                count_next = count - {{(N-1){1'b0}}, 1'b1};
            end
        end
    end

    // Outputs come straight from registers, so they are glitch-free
    always_comb begin
        qout = count;
        tc   = tc_reg;
        busy = (state == RUN);
    end

endmodule
